// File: rtl/cpa_pkg.sv
// Shared types and constants for the 13-bit shared-adder arbiter.
package cpa_pkg;

  localparam int unsigned W = 13;

  typedef enum logic {StEmpty, StFull} cpa_state_e;

  typedef logic cpa_id_t;

endpackage

// File: rtl/cpa13_cin.sv
// 13-stage full-adder ripple chain with carry-in; exposes carry into the MSB for overflow.
module cpa13_cin
  import cpa_pkg::*;
(
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_cin,
  output logic [W-1:0] o_sum,
  output logic         o_cout,
  output logic         o_c12
);

  logic [W:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar gi = 0; gi < W; gi++) begin : g_fa
    assign o_sum[gi]  = i_a[gi] ^ i_b[gi] ^ w_c[gi];
    assign w_c[gi+1]  = (i_a[gi] & i_b[gi]) | (w_c[gi] & (i_a[gi] ^ i_b[gi]));
  end

  assign o_cout = w_c[W];
  assign o_c12  = w_c[W-1];

endmodule

// File: rtl/cpa_share_arb.sv
// Round-robin arbiter sharing one 13-bit ripple adder between two requesters,
// with a single-entry result register tagged by requester ID.
module cpa_share_arb
  import cpa_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req0_sub,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic         req1_sub,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_sum,
  output logic         res_cout,
  output logic         res_ovf,
  output logic         res_id
);

  cpa_state_e   r_state, w_state_d;
  cpa_id_t      r_last_grant;
  logic [W-1:0] r_sum;
  logic         r_cout;
  logic         r_ovf;
  cpa_id_t      r_id;

  logic         w_can_accept;
  logic         w_grant;
  cpa_id_t      w_winner;
  logic [W-1:0] w_a;
  logic [W-1:0] w_b;
  logic         w_sub;
  logic [W-1:0] w_sum;
  logic         w_cout;
  logic         w_c12;

  // Gating with rst_n keeps both readys low while reset is held.
  assign w_can_accept = (r_state == StEmpty) || res_ready;
  assign w_grant      = rst_n && w_can_accept && (req0_valid || req1_valid);

  always_comb begin
    w_winner = 1'b0;
    if (req0_valid && req1_valid) begin
      w_winner = ~r_last_grant;
    end else if (req1_valid) begin
      w_winner = 1'b1;
    end
  end

  assign req0_ready = w_grant && (w_winner == 1'b0);
  assign req1_ready = w_grant && (w_winner == 1'b1);

  always_comb begin
    w_a   = req0_a;
    w_b   = req0_b;
    w_sub = req0_sub;
    if (w_winner == 1'b1) begin
      w_a   = req1_a;
      w_b   = req1_b;
      w_sub = req1_sub;
    end
  end

  cpa13_cin u_adder (
    .i_a    (w_a),
    .i_b    (w_b ^ {W{w_sub}}),
    .i_cin  (w_sub),
    .o_sum  (w_sum),
    .o_cout (w_cout),
    .o_c12  (w_c12)
  );

  always_comb begin
    w_state_d = r_state;
    if (w_grant) begin
      w_state_d = StFull;
    end else if (r_state == StFull && res_ready) begin
      w_state_d = StEmpty;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StEmpty;
      r_last_grant <= 1'b1;
      r_sum        <= '0;
      r_cout       <= 1'b0;
      r_ovf        <= 1'b0;
      r_id         <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (w_grant) begin
        r_last_grant <= w_winner;
        r_sum        <= w_sum;
        r_cout       <= w_cout;
        r_ovf        <= w_c12 ^ w_cout;
        r_id         <= w_winner;
      end
    end
  end

  assign res_valid = (r_state == StFull);
  assign res_sum   = r_sum;
  assign res_cout  = r_cout;
  assign res_ovf   = r_ovf;
  assign res_id    = r_id;

endmodule

// File: doc/cpa_share_arb.md
# cpa_share_arb

Round-robin arbiter and sequencer that shares one 13-bit ripple carry-propagate adder between two requesters. Each requester presents an add or subtract operation under a valid/ready handshake. The block grants at most one operation per cycle, drives the shared adder, and captures sum, carry-out and signed overflow in a single-entry result register, tagged with the winning requester ID. It sits between the word-level datapath clients and the 13-bit adder.

## Interface
- W, 13, operand/result width; the adder is fixed at 13 bits, so only 13 is supported.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid, req1_valid  in  1  requester has an operation pending.
- req0_ready, req1_ready  out  1  operation accepted this cycle (grant).
- req0_a, req0_b, req1_a, req1_b  in  W  operands.
- req0_sub, req1_sub  in  1  1 = a − b, 0 = a + b.
- res_valid  out  1  result register holds an unconsumed result.
- res_ready  in  1  consumer takes the result this cycle.
- res_sum  out  W  sum/difference, two's complement, mod 2^13.
- res_cout  out  1  carry out of bit 12; for subtract, 1 = no borrow.
- res_ovf  out  1  signed overflow: carry into bit 12 XOR carry out of bit 12.
- res_id  out  1  requester that issued this result.

## Operation
- State machine, 2 states:
  - EMPTY: res_valid = 0.
  - FULL: res_valid = 1.
- can_accept = EMPTY, or (FULL and res_ready).
- Grant when can_accept and at least one reqN_valid.
  - Only one requester is valid: it wins.
  - Both are valid: the requester other than last_grant wins.
  - The winner's ready is 1 for exactly that cycle; the other ready is 0.
  - last_grant updates to the winner on every grant.
- Adder inputs:
  - a = winner's a.
  - b = winner's b XOR {W{sub}}.
  - cin = sub.
  - The bit-0 half-adder slot is replaced by a full adder so that cin is honoured.
- On grant, the register loads sum, cout, ovf and the winner ID; state becomes or stays FULL.
- No grant while FULL with res_ready = 1: state goes to EMPTY.
- FULL with res_ready = 0: all res_* outputs hold stable; both readys are 0.
- Requesters hold a, b and sub stable while valid and not ready. The arbiter does not buffer ungranted requests.
- Ready depends combinationally on valid and res_ready. Valid never depends on ready.

## Timing
- Reset (async assert, sync release):
  - State = EMPTY, last_grant = 1, so requester 0 wins the first contention.
  - res_valid = 0, res_sum = 0, res_cout = 0, res_ovf = 0, res_id = 0.
  - req0_ready = req1_ready = 0.
- Latency: an operation granted at edge N has its result visible with res_valid = 1 after edge N (one cycle).
- Throughput: one operation per cycle while res_ready is held at 1.
- Simultaneous drain and grant in FULL: the old result is consumed and the new one loaded at the same edge; res_valid stays 1.
- Reset mid-operation: the pending result is discarded. No grant is issued while rst_n = 0.
- Ready outputs are 0 during reset.
- The adder path is combinational within one cycle. Critical path = 13-bit ripple plus the operand mux.

## Structure
- Package cpa_pkg:
  - localparam W = 13.
  - State enum {EMPTY, FULL}.
  - Requester ID type (1 bit).
- Sub-module cpa13_cin: a 13-stage full-adder ripple chain with cin.
  - Outputs: sum, cout, and carry into bit 12 (c12).
  - Overflow is computed in the parent as c12 XOR cout.
- Parent block contains: arbiter, operand mux with b-inversion, FSM, result register.

## Test plan
- Reset, then req0: a = 0x0FFF, b = 0x0001, add.
  - Grant on cycle 1.
  - Next cycle: res_sum = 0x1000, cout = 0, ovf = 1, id = 0.
- req1: a = 5, b = 7, sub.
  - res_sum = 0x1FFE, cout = 0, ovf = 0, id = 1.
- req0: a = 0x1000, b = 0x1000, add.
  - res_sum = 0x0000, cout = 1, ovf = 1.
- Both requesters held valid, res_ready = 1 for 6 cycles.
  - Grants alternate 0,1,0,1,0,1 (first grant 0 after reset).
  - res_valid stays 1 with one result per cycle.
- Backpressure: hold res_ready = 0 for 4 cycles while FULL.
  - Both readys are 0 and res_* outputs are stable.
  - Release res_ready: the drain and the next grant occur at the same edge.
- Assert rst_n = 0 while FULL with a pending request.
  - Outputs return to reset values immediately.
  - After release, the first contended grant goes to requester 0.
